restoring_div_64_32: RTL

//   Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient + N-bit remainder.

---
 rtl/restoring_div_64_32.sv | 69 ++++++
 1 files changed

// File: rtl/restoring_div_64_32.sv
// restoring_div_64_32: sequential restoring divider, N-bit dividend / M-bit divisor, one quotient bit per clock
module restoring_div_64_32 #(
  parameter int M = 32,
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [M-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] Q,
  output logic [M-1:0] R,
  output logic         div_zero,
  output logic         ovf
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [M:0] pr, shv, t;
  logic [M-1:0] sh, b;
  logic [$clog2(M)-1:0] cnt;
  logic acc, bz, of, ge;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    acc = in_valid && in_ready;
    bz = B == '0;
    of = A[N-1:M] >= B;
    shv = {pr[M-1:0], sh[M-1]};
    ge = shv >= {1'b0, b};
    t = shv - {1'b0, b};
    state_n = state == IDLE ? (acc ? ((bz || of) ? DONE : CALC) : IDLE) :
              state == CALC ? (cnt == '0 ? DONE : CALC) :
              (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pr <= '0;
      sh <= '0;
      b <= '0;
      cnt <= '0;
      Q <= '0;
      R <= '0;
      div_zero <= 1'b0;
      ovf <= 1'b0;
    end else if (acc) begin
      b <= B;
      pr <= {1'b0, A[N-1:M]};
      sh <= A[M-1:0];
      cnt <= $bits(cnt)'(M - 1);
      div_zero <= bz;
      ovf <= !bz && of;
      if (bz || of) begin
        Q <= '1;
        R <= bz ? A[M-1:0] : '0;
      end
    end else if (state == CALC) begin
      pr <= ge ? t : shv;
      sh <= sh << 1;
      Q <= {Q[M-2:0], ge};
      cnt <= cnt - 1'b1;
      if (cnt == '0) R <= ge ? t[M-1:0] : shv[M-1:0];
    end
endmodule
